// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: controller states,
// data-bus width and the default IO address of the mask register.
package interrupt_controller_pkg;

    localparam int DW = 16;
    localparam logic [3:0] MASK_IO_ADDR_DEFAULT = 4'hE;

    typedef enum logic [1:0] {
        IC_IDLE    = 2'd0,
        IC_ENTRY   = 2'd1,
        IC_SERVICE = 2'd2
    } ic_state_e;

endpackage

// File: rtl/interrupt_controller_if.sv
// Control-unit <-> interrupt controller handshake: entry/return strobes,
// IO write qualifier and the vector address handed to the address mux.
// The shared d_bus stays a plain inout on the controller.
interface interrupt_controller_if;
    import interrupt_controller_pkg::*;

    logic          io_interrupt;
    logic          io_store_retaddr;
    logic          io_push_int_addr;
    logic          io_push_retaddr;
    logic          io_push_ints;
    logic          io_write;
    logic [3:0]    io_addr;
    logic [DW-1:0] vec_addr;
    logic          vec_addr_en;

    modport master (
        input  io_interrupt, vec_addr, vec_addr_en,
        output io_store_retaddr, io_push_int_addr, io_push_retaddr,
               io_push_ints, io_write, io_addr
    );

    modport slave (
        output io_interrupt, vec_addr, vec_addr_en,
        input  io_store_retaddr, io_push_int_addr, io_push_retaddr,
               io_push_ints, io_write, io_addr
    );

endinterface

// File: rtl/interrupt_controller_prio_enc.sv
// Fixed-priority encoder: reports the lowest-index set request and
// whether any request is set at all.
module irq_priority_encoder #(
    parameter int NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic [3:0]         id,
    output logic               any
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        id  = '0;
        any = 1'b0;
        for (int unsigned i = NUM_IRQ; i > 0; i--) begin
            if (req[i-1]) begin
                id  = 4'(i - 1);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: per-line pending/mask state, single-level
// interrupt entry (return address capture, winner selection, vector
// address) and return-address / pending-vector readback on d_bus.
// Build option: define IRQ_LEVEL_EN for level-sensitive request lines.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int          NUM_IRQ      = 8,
    parameter logic [15:0] VEC_BASE     = 16'h0010,
    parameter logic [3:0]  MASK_IO_ADDR = MASK_IO_ADDR_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_IRQ-1:0]    irq_in,
    interrupt_controller_if.slave bus,
    inout  wire  [DW-1:0]         d_bus
);

    ic_state_e          state, state_next;
    logic [NUM_IRQ-1:0] pending, mask, irq_prev, clr;
    logic [DW-1:0]      ret_addr;
    logic [3:0]         win_id, win_idx;
    logic               win_any, store;
    logic               drive_en;
    logic [DW-1:0]      drive_val;

    // The fetch strobe needs no action: ENTRY advances on its own.
    logic unused_push_int_addr;
    assign unused_push_int_addr = bus.io_push_int_addr;

    irq_priority_encoder #(.NUM_IRQ(NUM_IRQ)) u_prio (
        .req (pending & ~mask),
        .id  (win_idx),
        .any (win_any)
    );

    assign store = (state == IC_IDLE) && bus.io_store_retaddr;

    // One-hot clear of the winning line on a committed entry.
    always_comb begin
        clr = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            clr[i] = store && win_any && (win_idx == 4'(i));
        end
    end

    // Pending, mask, return address and winner registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending  <= '0;
            mask     <= '0;
            ret_addr <= '0;
            irq_prev <= '0;
            win_id   <= '0;
        end else begin
            irq_prev <= irq_in;
`ifdef IRQ_LEVEL_EN
            pending  <= irq_in;
`else
            pending  <= (pending & ~clr) | (irq_in & ~irq_prev);
`endif
            if (bus.io_write && (bus.io_addr == MASK_IO_ADDR)) begin
                mask <= d_bus[NUM_IRQ-1:0];
            end
            if (store) begin
                ret_addr <= d_bus;
                win_id   <= win_any ? win_idx : 4'(NUM_IRQ);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IC_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, interrupt request and vector address.
    always_comb begin
        state_next       = state;
        bus.io_interrupt = 1'b0;
        bus.vec_addr_en  = 1'b0;
        bus.vec_addr     = '0;
        unique case (state)
            IC_IDLE: begin
                bus.io_interrupt = win_any;
                if (bus.io_store_retaddr) state_next = IC_ENTRY;
            end
            IC_ENTRY: begin
                bus.vec_addr_en = 1'b1;
                bus.vec_addr    = VEC_BASE + 16'(win_id);
                state_next      = IC_SERVICE;
            end
            IC_SERVICE: begin
                if (bus.io_push_retaddr) state_next = IC_IDLE;
            end
            default: state_next = IC_IDLE;
        endcase
    end

    // d_bus readback; return address outranks the pending vector.
    always_comb begin
        drive_en  = bus.io_push_retaddr | bus.io_push_ints;
        drive_val = '0;
        if (bus.io_push_retaddr) begin
            drive_val = ret_addr;
        end else if (bus.io_push_ints) begin
            drive_val[NUM_IRQ-1:0] = pending;
        end
    end

    assign d_bus = drive_en ? drive_val : 'z;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed vector table, then random
// traffic compared against a behavioural model of the controller.
module tb_interrupt_controller;

    localparam int N = 8;

    typedef struct {
        logic        rst;
        logic [7:0]  irq;
        logic [3:0]  s;      // {store_retaddr, push_int_addr, push_retaddr, push_ints}
        logic        wr;
        logic [3:0]  addr;
        logic        drv;
        logic [15:0] dval;
        logic [15:0] ebus;
        logic        eint;
        logic        even;
        logic [15:0] evaddr;
    } row_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] irq = '0;
    logic         drv = 1'b0;
    logic [15:0]  dval = '0;
    wire  [15:0]  d_bus;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Behavioural model: phase 0 waiting, 1 vector fetch, 2 in handler.
    logic [N-1:0] m_pend = '0, m_mask = '0, m_prev = '0;
    logic [15:0]  m_ret = '0;
    int           m_win = 0;
    int           m_phase = 0;

    row_t tbl[$];

    interrupt_controller_if bus_if();

    assign d_bus = drv ? dval : 16'bz;

    interrupt_controller #(
        .NUM_IRQ(N),
        .VEC_BASE(16'h0010),
        .MASK_IO_ADDR(4'hE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .irq_in(irq),
        .bus(bus_if),
        .d_bus(d_bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic row_t mk(input logic rst, input logic [7:0] irq_v, input logic [3:0] s,
                                input logic wr, input logic [3:0] addr, input logic dr,
                                input logic [15:0] dv, input logic [15:0] ebus,
                                input logic eint, input logic even, input logic [15:0] evaddr);
        row_t r;
        r.rst = rst; r.irq = irq_v; r.s = s; r.wr = wr; r.addr = addr;
        r.drv = dr; r.dval = dv; r.ebus = ebus; r.eint = eint; r.even = even; r.evaddr = evaddr;
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic drive(input row_t r);
        rst_n = r.rst;
        irq   = r.irq;
        bus_if.io_store_retaddr = r.s[3];
        bus_if.io_push_int_addr = r.s[2];
        bus_if.io_push_retaddr  = r.s[1];
        bus_if.io_push_ints     = r.s[0];
        bus_if.io_write         = r.wr;
        bus_if.io_addr          = r.addr;
        drv  = r.drv;
        dval = r.dval;
    endtask

    task automatic model_step();
        logic [N-1:0] clr;
        logic [N-1:0] edges;
        int w;
        clr = '0;
        if (!rst_n) begin
            m_pend = '0; m_mask = '0; m_prev = '0; m_ret = '0; m_win = 0; m_phase = 0;
            return;
        end
        edges  = irq & ~m_prev;
        m_prev = irq;
        if (m_phase == 0 && bus_if.io_store_retaddr) begin
            m_ret = dval;
            w = 0;
            while (w < N && !(m_pend[w] && !m_mask[w])) w++;
            if (w < N) clr[w] = 1'b1;
            m_win = w;
            m_phase = 1;
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (m_phase == 2 && bus_if.io_push_retaddr) begin
            m_phase = 0;
        end
        m_pend = (m_pend & ~clr) | edges;
        if (bus_if.io_write && bus_if.io_addr == 4'hE) m_mask = dval[N-1:0];
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    initial begin
        row_t r;
        logic [15:0] ebus;
        int sel;

        drive(mk(0, 8'h00, 4'b0000, 0, 4'h0, 0, 16'h0, 16'h0, 0, 0, 16'h0));
        @(negedge clk);
        finish_cycle();
        finish_cycle();

        // rst  irq    strobes   wr addr drv dval      ebus      int ven vaddr
        tbl.push_back(mk(1, 8'h00, 4'b0000, 0, 4'h0, 1, 16'hA5A5, 16'hA5A5, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 8'h08, 4'b0000, 0, 4'h0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 8'h08, 4'b0001, 0, 4'h0, 0, 16'h0000, 16'h0008, 1, 0, 16'h0000));
        tbl.push_back(mk(1, 8'h08, 4'b1100, 0, 4'h0, 1, 16'h0123, 16'h0123, 1, 0, 16'h0000));
        tbl.push_back(mk(1, 8'h08, 4'b0000, 0, 4'h0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0013));
        tbl.push_back(mk(1, 8'h08, 4'b0001, 0, 4'h0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 8'h08, 4'b0010, 0, 4'h0, 0, 16'h0000, 16'h0123, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 8'h00, 4'b0000, 0, 4'h0, 1, 16'h5A5A, 16'h5A5A, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 8'h24, 4'b0000, 0, 4'h0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 8'h24, 4'b1000, 0, 4'h0, 1, 16'h0456, 16'h0456, 1, 0, 16'h0000));
        tbl.push_back(mk(1, 8'h00, 4'b0000, 0, 4'h0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0012));
        tbl.push_back(mk(1, 8'h00, 4'b0010, 0, 4'h0, 0, 16'h0000, 16'h0456, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 8'h00, 4'b0001, 0, 4'h0, 0, 16'h0000, 16'h0020, 1, 0, 16'h0000));
        tbl.push_back(mk(1, 8'h00, 4'b1000, 0, 4'h0, 1, 16'h0777, 16'h0777, 1, 0, 16'h0000));
        tbl.push_back(mk(1, 8'h00, 4'b0000, 0, 4'h0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0015));
        tbl.push_back(mk(1, 8'h00, 4'b0010, 0, 4'h0, 0, 16'h0000, 16'h0777, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 8'h00, 4'b0000, 1, 4'hE, 1, 16'h0004, 16'h0004, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 8'h04, 4'b0000, 0, 4'h0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 8'h00, 4'b0001, 0, 4'h0, 0, 16'h0000, 16'h0004, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 8'h00, 4'b0000, 1, 4'hD, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 8'h00, 4'b0000, 1, 4'hE, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 8'h00, 4'b0000, 0, 4'h0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000));
        tbl.push_back(mk(1, 8'h00, 4'b1000, 0, 4'h0, 1, 16'h0100, 16'h0100, 1, 0, 16'h0000));
        tbl.push_back(mk(1, 8'h00, 4'b0000, 0, 4'h0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0012));
        tbl.push_back(mk(1, 8'h00, 4'b0010, 0, 4'h0, 0, 16'h0000, 16'h0100, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 8'h00, 4'b1100, 0, 4'h0, 1, 16'h0200, 16'h0200, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 8'h00, 4'b0000, 0, 4'h0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0018));
        tbl.push_back(mk(1, 8'h00, 4'b0010, 0, 4'h0, 0, 16'h0000, 16'h0200, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 8'h02, 4'b0000, 0, 4'h0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 8'h00, 4'b0000, 0, 4'h0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000));
        tbl.push_back(mk(1, 8'h02, 4'b1000, 0, 4'h0, 1, 16'h0300, 16'h0300, 1, 0, 16'h0000));
        tbl.push_back(mk(1, 8'h02, 4'b0000, 0, 4'h0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0011));
        tbl.push_back(mk(1, 8'h02, 4'b0001, 0, 4'h0, 0, 16'h0000, 16'h0002, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 8'h02, 4'b1000, 0, 4'h0, 1, 16'h0999, 16'h0999, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 8'h02, 4'b0011, 0, 4'h0, 0, 16'h0000, 16'h0300, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 8'h02, 4'b0000, 0, 4'h0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000));
        tbl.push_back(mk(1, 8'h02, 4'b1000, 0, 4'h0, 1, 16'h0400, 16'h0400, 1, 0, 16'h0000));
        tbl.push_back(mk(1, 8'h02, 4'b0000, 0, 4'h0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0011));
        tbl.push_back(mk(1, 8'h04, 4'b0000, 0, 4'h0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000));
        tbl.push_back(mk(0, 8'h04, 4'b0000, 0, 4'h0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 8'h00, 4'b0000, 0, 4'h0, 1, 16'h1234, 16'h1234, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 8'h00, 4'b0001, 0, 4'h0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 8'h00, 4'b0010, 0, 4'h0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 8'h00, 4'b0000, 0, 4'h0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000));

        foreach (tbl[i]) begin
            drive(tbl[i]);
            #2;
            chk($sformatf("row%0d io_interrupt", i), 16'(bus_if.io_interrupt), 16'(tbl[i].eint));
            chk($sformatf("row%0d vec_addr_en", i), 16'(bus_if.vec_addr_en), 16'(tbl[i].even));
            chk($sformatf("row%0d vec_addr", i), bus_if.vec_addr, tbl[i].evaddr);
            if (tbl[i].drv || tbl[i].s[1] || tbl[i].s[0])
                chk($sformatf("row%0d d_bus", i), d_bus, tbl[i].ebus);
            finish_cycle();
        end

        // Random traffic against the model.
        r = mk(1, 8'h00, 4'b0000, 0, 4'h0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
        for (int c = 0; c < 600; c++) begin
            r.rst  = 1'b1;
            r.irq  = r.irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            r.s    = 4'b0000;
            r.wr   = 1'b0;
            r.addr = 4'($urandom);
            r.drv  = 1'b0;
            r.dval = 16'($urandom);
            sel = $urandom_range(0, 19);
            case (sel)
                0, 1, 2: begin r.s = {1'b1, 1'($urandom), 2'b00}; r.drv = 1'b1; end
                3:       r.s = 4'b0100;
                4, 5:    r.s = 4'b0010;
                6:       r.s = 4'b0001;
                7:       r.s = 4'b0011;
                8:       begin r.wr = 1'b1; r.addr = 4'hE; r.drv = 1'b1;
                               r.dval = 16'($urandom) & 16'($urandom); end
                9:       begin r.wr = 1'b1; r.drv = 1'b1; end
                10:      r.rst = ($urandom_range(0, 4) != 0);
                default: r.drv = 1'($urandom);
            endcase
            drive(r);
            #2;
            chk($sformatf("rnd%0d io_interrupt", c), 16'(bus_if.io_interrupt),
                16'((m_phase == 0) && ((m_pend & ~m_mask) != '0)));
            chk($sformatf("rnd%0d vec_addr_en", c), 16'(bus_if.vec_addr_en), 16'(m_phase == 1));
            chk($sformatf("rnd%0d vec_addr", c), bus_if.vec_addr,
                (m_phase == 1) ? 16'h0010 + 16'(m_win) : 16'h0000);
            if (r.drv || r.s[1] || r.s[0]) begin
                if (r.drv)       ebus = r.dval;
                else if (r.s[1]) ebus = m_ret;
                else             ebus = {8'h00, m_pend};
                chk($sformatf("rnd%0d d_bus", c), d_bus, ebus);
            end
            finish_cycle();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
